// File: rtl/game_board_mem.sv
// game_board_mem: Wishbone pipelined slave holding the minesweeper board (one cell per address).
// Latency: accepted request acked one cycle later; read data valid with the ack and held until the next read ack.
// Backpressure: wb_stall_o is high only during a clear sweep (BOARD_DEPTH cycles); no requests are accepted then.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   clear_i                   one-cycle request to zero the whole board (ignored while sweeping)
//   wb_cyc_i/stb_i/we_i       bus cycle, strobe, write enable
//   wb_adr_i, wb_dat_i        cell address and write data
//   wb_dat_o, wb_ack_o        read data and completion pulse
//   wb_stall_o, busy_o        both high while the clear sweep runs
//   mine_cnt_o                number of in-range cells whose mine flag (MSB) is set
module game_board_mem #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int BOARD_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH:0]   mine_cnt_o,
  output logic                  busy_o
);

  localparam int IDX_W = (BOARD_DEPTH > 1) ? $clog2(BOARD_DEPTH) : 1;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_mem [BOARD_DEPTH];
  logic [IDX_W-1:0]      r_sweep_cnt;
  logic [DATA_WIDTH-1:0] r_dat;
  logic                  r_ack;
  logic [ADDR_WIDTH:0]   r_mine_cnt;

  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_wr;
  logic                  w_sweep_last;
  logic                  w_old_flag;
  logic                  w_new_flag;
  logic [IDX_W-1:0]      w_idx;

  assign wb_stall_o   = (r_state == SWEEP);
  assign busy_o       = (r_state == SWEEP);
  assign wb_ack_o     = r_ack;
  assign wb_dat_o     = r_dat;
  assign mine_cnt_o   = r_mine_cnt;

  assign w_accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  // Extra bit so the compare also works when BOARD_DEPTH == 2**ADDR_WIDTH.
  assign w_in_range   = ({1'b0, wb_adr_i} < (ADDR_WIDTH+1)'(BOARD_DEPTH));
  // Low bits are only used to index r_mem when w_in_range holds.
  assign w_idx        = wb_adr_i[IDX_W-1:0];
  assign w_wr         = w_accept & wb_we_i & w_in_range;
  assign w_sweep_last = (r_sweep_cnt == IDX_W'(BOARD_DEPTH - 1));
  assign w_old_flag   = r_mem[w_idx][DATA_WIDTH-1];
  assign w_new_flag   = wb_dat_i[DATA_WIDTH-1];

  // Next-state logic. A request accepted together with clear_i is still
  // served this cycle; the sweep that follows erases it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (clear_i)      w_state_nxt = SWEEP;
      SWEEP:   if (w_sweep_last) w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Cell array. Sweep writes and bus writes never coincide because no
  // request is accepted while sweeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BOARD_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == SWEEP) begin
      r_mem[r_sweep_cnt] <= '0;
    end else if (w_wr) begin
      r_mem[w_idx] <= wb_dat_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sweep_cnt <= '0;
      r_ack       <= 1'b0;
      r_dat       <= '0;
      r_mine_cnt  <= '0;
    end else begin
      r_ack <= w_accept;

      if (w_accept && !wb_we_i) begin
        r_dat <= w_in_range ? r_mem[w_idx] : '0;
      end

      if (r_state == SWEEP) begin
        r_sweep_cnt <= w_sweep_last ? '0 : r_sweep_cnt + IDX_W'(1);
      end

      // Count delta uses the pre-write flag so overwrites are tracked exactly.
      if ((r_state == SWEEP) && w_sweep_last) begin
        r_mine_cnt <= '0;
      end else if (w_wr) begin
        r_mine_cnt <= r_mine_cnt + (ADDR_WIDTH+1)'(w_new_flag)
                                 - (ADDR_WIDTH+1)'(w_old_flag);
      end
    end
  end

endmodule

// File: tb/tb_game_board_mem.sv
// tb_game_board_mem: drives a full-depth board (256 cells) and a short board (100 cells)
// from one shared bus and checks both against a cell-array reference model every cycle.
// Directed scenarios (write/read, streaming, out of range, clear, reset mid-sweep) plus random traffic.
module tb_game_board_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       cyc, stb, we;
  logic [7:0] adr, dat;

  logic [7:0] dat_o   [2];
  logic       ack_o   [2];
  logic       stall_o [2];
  logic       busy_o  [2];
  logic [8:0] cnt_o   [2];

  always #5 clk = ~clk;

  game_board_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BOARD_DEPTH(256)) dut_full (
    .clk(clk), .rst(rst), .clear_i(clear),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(dat_o[0]), .wb_ack_o(ack_o[0]), .wb_stall_o(stall_o[0]),
    .mine_cnt_o(cnt_o[0]), .busy_o(busy_o[0])
  );

  game_board_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .BOARD_DEPTH(100)) dut_short (
    .clk(clk), .rst(rst), .clear_i(clear),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat),
    .wb_dat_o(dat_o[1]), .wb_ack_o(ack_o[1]), .wb_stall_o(stall_o[1]),
    .mine_cnt_o(cnt_o[1]), .busy_o(busy_o[1])
  );

  // Reference model: plain cell arrays, a remaining-sweep-cycles count and the
  // mine count frozen at the moment the clear was taken.
  int         depth [2] = '{256, 100};
  logic [7:0] m_mem [2][256];
  int         m_left   [2];
  int         m_frozen [2];
  logic       m_ack [2];
  logic [7:0] m_dat [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int mines(input int k);
    int n;
    n = 0;
    for (int i = 0; i < depth[k]; i++) if (m_mem[k][i][7]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) m_mem[k][i] = 8'h00;
      m_left[k] = 0; m_frozen[k] = 0; m_ack[k] = 1'b0; m_dat[k] = 8'h00;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit busy, acc;
      busy = (m_left[k] > 0);
      acc  = cyc && stb && !busy;
      m_ack[k] = acc;
      if (acc && we && (int'(adr) < depth[k])) m_mem[k][adr] = dat;
      if (acc && !we) m_dat[k] = (int'(adr) < depth[k]) ? m_mem[k][adr] : 8'h00;
      if (busy) begin
        m_left[k]--;
      end else if (clear) begin
        m_frozen[k] = mines(k);
        for (int i = 0; i < 256; i++) m_mem[k][i] = 8'h00;
        m_left[k] = depth[k];
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_val($sformatf("ack%0d", k),   32'(ack_o[k]),   32'(m_ack[k]));
      check_val($sformatf("stall%0d", k), 32'(stall_o[k]), 32'(m_left[k] > 0));
      check_val($sformatf("busy%0d", k),  32'(busy_o[k]),  32'(m_left[k] > 0));
      check_val($sformatf("dat%0d", k),   32'(dat_o[k]),   32'(m_dat[k]));
      check_val($sformatf("cnt%0d", k),   32'(cnt_o[k]),
                (m_left[k] > 0) ? 32'(m_frozen[k]) : 32'(mines(k)));
    end
  endtask

  // One bus cycle: drive on the falling edge, model the rising edge, sample 1 after it.
  task automatic step(input logic c, input logic s, input logic w,
                      input logic [7:0] a, input logic [7:0] d, input logic clr);
    @(negedge clk);
    cyc = c; stb = s; we = w; adr = a; dat = d; clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
  endtask

  int n0, n1;

  initial begin
    rst = 1'b1; clear = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 8'h00; dat = 8'h00;
    model_reset();
    #1 compare_all();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single write then read.
    step(1, 1, 1, 8'd3, 8'h85, 0);
    check_val("wr3_ack", 32'(ack_o[0]), 32'd1);
    step(1, 1, 0, 8'd3, 8'h00, 0);
    check_val("rd3_dat", 32'(dat_o[0]), 32'h85);
    check_val("rd3_cnt", 32'(cnt_o[0]), 32'd1);

    // Streaming writes, then overwrite adr 5.
    for (int i = 0; i < 10; i++) step(1, 1, 1, 8'(i), 8'h80, 0);
    check_val("stream_cnt", 32'(cnt_o[0]), 32'd10);
    step(1, 1, 1, 8'd5, 8'h00, 0);
    check_val("clr5_cnt", 32'(cnt_o[0]), 32'd9);
    step(1, 1, 1, 8'd5, 8'h81, 0);
    check_val("set5_cnt", 32'(cnt_o[0]), 32'd10);

    // Out of range on the 100-cell board.
    step(1, 1, 1, 8'd150, 8'h80, 0);
    check_val("oor_wr_ack", 32'(ack_o[1]), 32'd1);
    check_val("oor_wr_cnt", 32'(cnt_o[1]), 32'd10);
    step(1, 1, 0, 8'd150, 8'h00, 0);
    check_val("oor_rd_ack", 32'(ack_o[1]), 32'd1);
    check_val("oor_rd_dat", 32'(dat_o[1]), 32'h00);

    // Clear sweep with requests pushing against the stall.
    for (int i = 0; i < 20; i++) step(1, 1, 1, 8'(i * 13), 8'h80, 0);
    step(0, 0, 0, 8'h00, 8'h00, 1);
    n0 = 0; n1 = 0;
    while (stall_o[0] === 1'b1 && n0 < 400) begin
      n0++;
      if (stall_o[1] === 1'b1) n1++;
      step(1, 1, 1'($urandom), 8'($urandom), 8'($urandom), 0);
    end
    check_val("sweep_len_full", 32'(n0), 32'd256);
    check_val("sweep_len_short", 32'(n1), 32'd100);
    check_val("sweep_cnt", 32'(cnt_o[0]), 32'd0);
    step(1, 1, 0, 8'd0, 8'h00, 0);
    check_val("rd0_after_clr", 32'(dat_o[0]), 32'h00);
    step(1, 1, 0, 8'd128, 8'h00, 0);
    step(1, 1, 0, 8'd255, 8'h00, 0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom % 4 != 0), 1'($urandom % 4 != 0), 1'($urandom), 8'($urandom),
           8'($urandom), 1'($urandom % 300 == 0));
    end
    n0 = 0;
    while ((stall_o[0] === 1'b1 || stall_o[1] === 1'b1) && n0 < 300) begin
      n0++;
      idle();
    end

    // Clear together with an accepted write.
    step(1, 1, 1, 8'd7, 8'h80, 1);
    check_val("clrwr_ack", 32'(ack_o[0]), 32'd1);
    check_val("clrwr_stall", 32'(stall_o[0]), 32'd1);
    n0 = 0;
    while (stall_o[0] === 1'b1 && n0 < 300) begin
      n0++;
      idle();
    end
    check_val("clrwr_len", 32'(n0), 32'd256);
    step(1, 1, 0, 8'd7, 8'h00, 0);
    check_val("clrwr_rd7", 32'(dat_o[0]), 32'h00);
    check_val("clrwr_cnt", 32'(cnt_o[0]), 32'd0);

    // Reset 40 cycles into a sweep.
    for (int i = 0; i < 8; i++) step(1, 1, 1, 8'(i), 8'h80, 0);
    step(1, 1, 0, 8'd3, 8'h00, 1);
    repeat (40) idle();
    rst = 1'b1;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 0, 8'd3, 8'h00, 0);
    check_val("rst_rd_ack", 32'(ack_o[0]), 32'd1);
    check_val("rst_rd_dat", 32'(dat_o[0]), 32'h00);
    check_val("rst_stall", 32'(stall_o[0]), 32'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
